// File: rtl/fsm_pkg.sv
// Shared definitions for the soft-start ramp path.
// Holds the ramp FSM state encoding, the speed-level percentages decoded
// from the one-hot level requests, the duty width, and a helper that turns
// a percentage of the PWM period into a duty value.
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2,
      HOLD      = 2'd3
   } state_t;

   localparam int unsigned LVL30_PCT  = 30;
   localparam int unsigned LVL50_PCT  = 50;
   localparam int unsigned LVL100_PCT = 100;

   localparam int DUTY_W = 8;

   // Floor of period*pct/100, e.g. 30 % of 100 ticks is 30 duty units.
   function automatic logic [DUTY_W-1:0] pct_to_duty(input int unsigned period,
                                                      input int unsigned pct);
      return DUTY_W'((period * pct) / 32'd100);
   endfunction

endpackage

// File: rtl/ramp_pwm_driver_if.sv
// Bundle between the ramp FSM and the PWM driver.
//   en         drive enable (0 ramps the output down to 0)
//   lvl_30/50/100  one-hot speed-level requests, asynchronous to clk
//   pwm_out    PWM motor drive
//   duty       currently applied duty (0..PERIOD)
//   at_target  applied duty equals the decoded target
//   lvl_fault  sticky flag: more than one level request seen at once
// master: the ramp FSM side; slave: the PWM driver.
interface ramp_pwm_driver_if;

   logic                       en;
   logic                       lvl_30;
   logic                       lvl_50;
   logic                       lvl_100;
   logic                       pwm_out;
   logic [fsm_pkg::DUTY_W-1:0] duty;
   logic                       at_target;
   logic                       lvl_fault;

   modport master (
      output en, lvl_30, lvl_50, lvl_100,
      input  pwm_out, duty, at_target, lvl_fault
   );

   modport slave (
      input  en, lvl_30, lvl_50, lvl_100,
      output pwm_out, duty, at_target, lvl_fault
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent single-bit signals.
//   clk    destination clock
//   reset  asynchronous, active-high reset (both stages clear to 0)
//   d      asynchronous inputs
//   q      inputs retimed into clk, two cycles later
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/ramp_pwm_driver.sv
// Slew-limited PWM driver behind the soft-start ramp FSM.
// Decodes the one-hot level requests into a target duty, walks the applied
// duty toward it by SLEW_STEP every SLEW_PERIODS PWM periods, and drives a
// registered PWM output whose duty only changes at a period boundary.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    slave side of ramp_pwm_driver_if (level/enable in, PWM/status out)
module ramp_pwm_driver
   import fsm_pkg::*;
#(
   parameter int unsigned PERIOD       = 100,
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned SLEW_STEP    = 5,
   parameter int unsigned SLEW_PERIODS = 2
) (
   input  logic               clk,
   input  logic               reset,
   ramp_pwm_driver_if.slave   bus
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLEW_W = (SLEW_PERIODS > 1) ? $clog2(SLEW_PERIODS) : 1;
   localparam int WIDE_W = DUTY_W + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [SLEW_W-1:0] SLEW_LAST  = SLEW_W'(SLEW_PERIODS - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] DUTY_FULL  = pct_to_duty(PERIOD, LVL100_PCT);
   localparam logic [DUTY_W-1:0] DUTY_HALF  = pct_to_duty(PERIOD, LVL50_PCT);
   localparam logic [DUTY_W-1:0] DUTY_LOW   = pct_to_duty(PERIOD, LVL30_PCT);
   localparam logic [DUTY_W-1:0] STEP_N     = DUTY_W'(SLEW_STEP);
   localparam logic [WIDE_W-1:0] STEP_WIDE  = WIDE_W'(SLEW_STEP);

   logic [3:0]        sync_out;
   logic              en_s, l100_s, l50_s, l30_s;
   logic [DUTY_W-1:0] target;
   logic              multi_lvl;

   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [SLEW_W-1:0] slew_cnt_q, slew_cnt_d;
   logic              tick, end_of_period, slew_evt, entering_ramp;

   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              pwm_out_q, pwm_out_d;
   logic              at_target_q, at_target_d;
   logic              lvl_fault_q, lvl_fault_d;

   logic [WIDE_W-1:0] up_sum;
   logic [DUTY_W-1:0] up_next, down_raw, down_next;

   // Level requests come from a slow, unrelated domain; only the retimed
   // copies are ever looked at below.
   sync_2ff #(.WIDTH(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({bus.en, bus.lvl_100, bus.lvl_50, bus.lvl_30}),
      .q     (sync_out)
   );

   assign en_s   = sync_out[3];
   assign l100_s = sync_out[2];
   assign l50_s  = sync_out[1];
   assign l30_s  = sync_out[0];

   // Target decode: highest requested level wins, disable forces zero.
   always_comb begin
      target = '0;
      if (en_s) begin
         if (l100_s) begin
            target = DUTY_FULL;
         end else if (l50_s) begin
            target = DUTY_HALF;
         end else if (l30_s) begin
            target = DUTY_LOW;
         end
      end
      multi_lvl = (l100_s & l50_s) | (l100_s & l30_s) | (l50_s & l30_s);
   end

   // Free-running timebase: clock divider, PWM period counter and the
   // count of completed periods that paces slew updates. The slew count
   // restarts whenever a new ramp begins so the first step is a full
   // SLEW_PERIODS away.
   always_comb begin
      tick          = (div_cnt_q == DIV_LAST);
      div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
      pwm_cnt_d     = pwm_cnt_q;
      if (tick) begin
         pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
      end
      end_of_period = tick && (pwm_cnt_q == CNT_LAST);
      slew_evt      = end_of_period && (slew_cnt_q == SLEW_LAST);
      entering_ramp = (state_d != state_q) &&
                      ((state_d == RAMP_UP) || (state_d == RAMP_DOWN));
      slew_cnt_d    = slew_cnt_q;
      if (entering_ramp) begin
         slew_cnt_d = '0;
      end else if (end_of_period) begin
         slew_cnt_d = slew_evt ? '0 : slew_cnt_q + 1'b1;
      end
   end

   // Ramp FSM. Duty only moves on slew_evt, which is itself a period
   // boundary, so the PWM never sees a duty change mid-period. The upward
   // sum is one bit wider so a step near the top cannot wrap; the downward
   // step saturates at zero before clamping to the target.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;

      up_sum  = {1'b0, duty_q} + STEP_WIDE;
      up_next = (up_sum > {1'b0, target}) ? target : up_sum[DUTY_W-1:0];

      down_raw  = ({1'b0, duty_q} < STEP_WIDE) ? '0 : duty_q - STEP_N;
      down_next = (down_raw < target) ? target : down_raw;

      case (state_q)
         IDLE: begin
            if (target != '0) begin
               state_d = RAMP_UP;
            end
         end
         RAMP_UP: begin
            if (target < duty_q) begin
               state_d = RAMP_DOWN;
            end else if (target == duty_q) begin
               state_d = HOLD;
            end else if (slew_evt) begin
               duty_d = up_next;
               if (up_next == target) begin
                  state_d = HOLD;
               end
            end
         end
         RAMP_DOWN: begin
            if (target > duty_q) begin
               state_d = RAMP_UP;
            end else if (target == duty_q) begin
               state_d = (target == '0) ? IDLE : HOLD;
            end else if (slew_evt) begin
               duty_d = down_next;
               if (down_next == target) begin
                  state_d = (target == '0) ? IDLE : HOLD;
               end
            end
         end
         HOLD: begin
            if (target > duty_q) begin
               state_d = RAMP_UP;
            end else if (target < duty_q) begin
               state_d = RAMP_DOWN;
            end else if (duty_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs: PWM compare, target match and the sticky
   // multi-level fault.
   always_comb begin
      pwm_out_d   = (pwm_cnt_q < duty_q);
      at_target_d = (duty_q == target);
      lvl_fault_d = lvl_fault_q | multi_lvl;
   end

   // at_target resets high because zero duty matches the zero target that
   // reset implies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q   <= '0;
         pwm_cnt_q   <= '0;
         slew_cnt_q  <= '0;
         state_q     <= IDLE;
         duty_q      <= '0;
         pwm_out_q   <= 1'b0;
         at_target_q <= 1'b1;
         lvl_fault_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         slew_cnt_q  <= slew_cnt_d;
         state_q     <= state_d;
         duty_q      <= duty_d;
         pwm_out_q   <= pwm_out_d;
         at_target_q <= at_target_d;
         lvl_fault_q <= lvl_fault_d;
      end
   end

   assign bus.pwm_out   = pwm_out_q;
   assign bus.duty      = duty_q;
   assign bus.at_target = at_target_q;
   assign bus.lvl_fault = lvl_fault_q;

endmodule

// File: doc/ramp_pwm_driver.md
Name: ramp_pwm_driver

Overview:
- Downstream consumer of the partial-ramp soft-start FSM. Converts its one-hot speed-level outputs (30 % / 50 % / 100 %) into a glitch-free PWM motor drive.
- Duty cycle slews toward the requested level at a controlled rate instead of stepping.
- Sits between the ramp FSM and the uo_out pins of the TinyTapeout top.
- Level inputs originate in the prescaled 1 Hz domain and are synchronised here.

Parameters:
- PERIOD, 100, PWM counter period in clk cycles after division; duty is expressed in the same units (0..PERIOD).
- CLK_DIV, 4, clk cycles per PWM counter tick (≥1).
- SLEW_STEP, 5, duty units added or removed per slew update.
- SLEW_PERIODS, 2, number of completed PWM periods between slew updates (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  drive enable; 0 forces the target to 0 (ramp-down, not cut)
- lvl_30  in  1  level request from ramp FSM, asynchronous
- lvl_50  in  1  level request, asynchronous
- lvl_100  in  1  level request, asynchronous
- pwm_out  out  1  PWM drive
- duty  out  8  current applied duty (0..PERIOD)
- at_target  out  1  duty equals decoded target
- lvl_fault  out  1  sticky; more than one level seen simultaneously

Behaviour:
- Reset (async assert, sync release): every register 0. pwm_out=0, duty=0, at_target=1, lvl_fault=0, state=IDLE.
- Synchroniser: each lvl_* and en passes through a 2-flop synchroniser. Decode uses synchronised values only, giving 2-cycle input latency.
- Target decode (combinational on synced inputs), priority 100 > 50 > 30:
  - lvl_100 → PERIOD
  - lvl_50 → PERIOD/2
  - lvl_30 → (PERIOD*3)/10, integer floor
  - none → 0
  - en=0 → 0
- lvl_fault: set when ≥2 synced lvl_* are high in the same cycle. Cleared only by reset. Decode still applies priority.
- Divider: div_cnt counts 0..CLK_DIV-1 and emits tick when div_cnt==CLK_DIV-1.
- PWM counter:
  - pwm_cnt advances on tick, 0..PERIOD-1, and wraps to 0.
  - end_of_period = tick && pwm_cnt==PERIOD-1.
- pwm_out is registered; next value = (pwm_cnt < duty_applied).
  - duty=0 → constantly 0.
  - duty=PERIOD → constantly 1.
- Glitch-free update: duty_applied is loaded only on end_of_period. Output duty reflects duty_applied.
- Slew timing:
  - slew_cnt counts end_of_period events 0..SLEW_PERIODS-1.
  - slew_evt fires on end_of_period when slew_cnt==SLEW_PERIODS-1.
  - slew_cnt resets to 0 on every state change into RAMP_UP or RAMP_DOWN.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
  - IDLE (duty==0): target>0 → RAMP_UP.
  - RAMP_UP:
    - on slew_evt, duty = min(duty+SLEW_STEP, target), computed 1 bit wider to avoid overflow.
    - duty reaches target → HOLD.
    - target drops below duty → RAMP_DOWN at once, no partial step.
  - RAMP_DOWN:
    - on slew_evt, duty = max(duty−SLEW_STEP, target), saturating at 0.
    - duty==target → HOLD, or → IDLE if target==0.
    - target rises above duty → RAMP_UP.
  - HOLD: target>duty → RAMP_UP; target<duty → RAMP_DOWN; target==0 and duty==0 → IDLE.
- Any new target value takes effect from the next cycle. In-flight steps are never undone.
- at_target is registered: (duty_applied == target).
- Reset mid-ramp: outputs go to 0 immediately (asynchronous). No ramp-down on reset.
- Divider and PWM counters free-run regardless of en.

Decomposition:
- Shared package fsm_pkg holds:
  - state enum (IDLE, RAMP_UP, RAMP_DOWN, HOLD)
  - level-percent constants LVL30_PCT=30, LVL50_PCT=50, LVL100_PCT=100
  - duty width constant DUTY_W=8
- One sub-module: sync_2ff (parameterised width, async active-high reset), instantiated once for the 4 inputs.
- PWM counter, slew logic and FSM stay in ramp_pwm_driver.

Test Plan:
1. Reset then lvl_30=1, en=1, defaults → duty steps 0,5,…,25,30, one step every 2 PWM periods (2×400 clk = 800 clk per step); at_target=1 at 30; pwm_out high for 30 of each 100 ticks.
2. From HOLD at 30, switch to lvl_100 → duty ramps 30→100 in 14 steps; at 100 pwm_out is constantly 1 across period wrap.
3. From 100, en=0 → RAMP_DOWN to 0 in 20 steps; IDLE reached; pwm_out constantly 0; at_target=1.
4. lvl_50 and lvl_100 both high for 3 cycles → lvl_fault=1 and stays 1 after inputs clear; target follows 100.
5. Mid-ramp-up at duty=20 toward 50, change to lvl_30 → continues up to 30 with no overshoot beyond 30, then HOLD; a change below current duty mid-ramp goes straight to RAMP_DOWN.
6. Assert reset mid-period while pwm_out=1 → pwm_out, duty and lvl_fault go to 0 in the same cycle, asynchronously. A 1-cycle input pulse shorter than the synchroniser is either ignored or seen, but never corrupts state.
